constraint_sample_driver: RTL and testbench
===========================================

# constraint_sample_driver

Upstream stimulus stage for the generated constraint-checker modules. It fills a packed candidate vector from a seeded LFSR and presents it to the combinational checker. The checker returns its single `x` result, and the driver streams every satisfying candidate downstream through a valid/ready handshake. It stops when the requested sample count or the try budget is reached, and keeps try and hit statistics.

## Interface
Parameters:
- `VEC_W`, default 394: total candidate width, equal to the sum of the checker's input widths. `var_0` occupies the LSBs, and each later `var_N` is packed directly above the previous one.
- `FILL_W`, default 32: LFSR bits inserted per fill cycle. Fixed at 32.
- `FILL_CYC`, default ceil(`VEC_W`/`FILL_W`) = 13: number of fill cycles per candidate.

Ports:
- `clk` in 1: the single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle pulse. Sampled only in IDLE or DONE.
- `seed` in 32: LFSR seed, captured on `start`. A value of 0 is replaced by 32'h1.
- `num_samples` in 16: samples wanted, captured on `start`. A value of 0 means finish immediately.
- `max_tries` in 32: candidate budget, captured on `start`. A value of 0 means unlimited.
- `cand` out `VEC_W`: candidate driven to the checker. Stable throughout CHECK and EMIT.
- `sat` in 1: the checker's `x`.
- `sample_valid` out 1: a satisfying sample is available.
- `sample_ready` in 1: downstream accepts the sample.
- `sample_data` out `VEC_W`: equal to `cand` while `sample_valid` is high.
- `busy` out 1: high in FILL, CHECK and EMIT.
- `done` out 1: one-cycle pulse on entry to DONE.
- `exhausted` out 1: sticky. Set when DONE was reached because the try budget ran out; cleared on `start`.
- `tries_cnt` out 32: candidates checked. Saturates at all-ones.
- `hits_cnt` out 16: samples accepted downstream.

## Operation
- LFSR: 32-bit Galois, taps mask 32'h80200003. The state advances one step per FILL cycle. Each FILL cycle does `cand <= {cand[VEC_W-33:0], lfsr_next}`.
- States: IDLE, FILL, CHECK, EMIT, DONE.
- IDLE or DONE on `start`:
  - Load `lfsr <= seed` (or 1 if `seed` is 0).
  - Clear `tries_cnt`, `hits_cnt` and `exhausted`.
  - If `num_samples` is 0, go to DONE. Otherwise go to FILL with `fill_ctr` = 0.
- FILL: shift in one word per cycle. After `FILL_CYC` cycles go to CHECK.
- CHECK: lasts one cycle. Register `sat` and increment `tries_cnt`, then branch:
  - If `sat` is 1, go to EMIT.
  - Else if the budget is hit (`max_tries` != 0 and the new `tries_cnt` equals `max_tries`), set `exhausted` and go to DONE.
  - Otherwise go to FILL.
- EMIT:
  - `sample_valid` is high, and `cand` and `sample_data` are held until `sample_ready`.
  - On handshake, increment `hits_cnt`.
  - If `hits_cnt` reaches `num_samples`, go to DONE.
  - Else if the budget is hit, set `exhausted` and go to DONE.
  - Otherwise go to FILL.
- DONE: `done` pulses on entry. The block waits for `start`; `cand` holds its last value.
- Reset values: state IDLE, `lfsr` 32'h1, `cand` 0, `sample_valid` 0, `busy` 0, `done` 0, `exhausted` 0, `tries_cnt` 0, `hits_cnt` 0.
- Reset mid-operation: everything returns to the reset values immediately. A pending sample is dropped, not emitted.
- `start` while `busy` is ignored.

## Timing
- `start` is sampled at edge 0. FILL occupies edges 1..13 and CHECK edge 14.
- On a hit, `sample_valid` rises after edge 14, i.e. 14 cycles after `start`.
- A failing try costs 14 cycles.
- A hit with `sample_ready` tied high costs 15 cycles: 13 FILL, 1 CHECK, 1 EMIT.
- `sat` must settle combinationally within the CHECK cycle. `cand` is registered, so there is no combinational path from `cand` to `sat` back to the outputs.
- `sample_valid` must not drop without a handshake; `sample_data` is stable while valid and not ready.
- `done` is asserted exactly one cycle, in the cycle after the final handshake or the final CHECK.

## Structure
- Shared package `sampler_pkg`:
  - `LFSR_TAPS` = 32'h80200003.
  - `FILL_W` = 32.
  - State enum `drv_state_t` {IDLE, FILL, CHECK, EMIT, DONE}.
  - `VEC_W` for the current generated checker.
- Natural sub-module: `lfsr32_galois`, with `clk`, `rst_n`, `load`, `seed`, `step` and `q`. It performs the zero-seed substitution internally.
- Top level is `constraint_sample_driver`. The bench wires it to the generated checker through a pack/unpack of `cand`.

## Test plan
- Stub checker with `sat` = 1, `num_samples` = 3, `sample_ready` = 1:
  - Expect three samples at 14, 29 and 44 cycles after `start`.
  - Expect `done` at cycle 45, `tries_cnt` 3, `hits_cnt` 3, `exhausted` 0.
- Stub `sat` = 0, `max_tries` = 5:
  - Expect DONE after 70 cycles, `exhausted` = 1, `tries_cnt` 5, and no `sample_valid`.
- `seed` = 0 versus `seed` = 1: the `cand` sequences must be identical.
  - The first FILL word must equal the Galois step of 32'h1, which is 32'h80200003.
- Backpressure: `sat` = 1, `sample_ready` held low for 10 cycles.
  - `sample_valid` and `sample_data` stay constant for 10 cycles, `hits_cnt` updates only on the handshake, and the LFSR does not advance.
- Real generated checker, `seed` = 32'hACE1, `num_samples` = 4, `max_tries` = 0:
  - Every emitted `sample_data`, unpacked, must re-evaluate to `x` = 1 in a reference model.
- `rst_n` asserted during EMIT:
  - All outputs return to reset values asynchronously.
  - A new `start` after release reproduces the same first candidate for the same seed.

Source files
------------

// File: rtl/sampler_pkg.sv
// Shared definitions for the constraint-checker stimulus path: LFSR taps,
// fill width, driver states and the packed candidate width of the current checker.
package sampler_pkg;

  localparam logic [31:0] LFSR_TAPS = 32'h80200003;
  localparam int          FILL_W    = 32;
  localparam int          VEC_W     = 394;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    CHECK,
    EMIT,
    DONE
  } drv_state_t;

  // One right-shifting Galois step; the shifted-out bit folds the taps back in.
  function automatic logic [31:0] galois_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

endpackage

// File: rtl/lfsr32_galois.sv
// 32-bit Galois LFSR with synchronous load and step enable.
// An all-zero seed would lock the register, so it is replaced by 1.
module lfsr32_galois
  import sampler_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] seed,
  input  logic        step,
  output logic [31:0] q
);

  logic [31:0] r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= 32'h1;
    end else if (load) begin
      r_q <= (seed == 32'h0) ? 32'h1 : seed;
    end else if (step) begin
      r_q <= galois_step(r_q);
    end
  end

  assign q = r_q;

endmodule

// File: rtl/constraint_sample_driver.sv
// Fills a candidate vector from an LFSR, presents it to a combinational checker
// and streams every satisfying candidate out over a valid/ready handshake.
module constraint_sample_driver
  import sampler_pkg::*;
#(
  parameter int VEC_W    = sampler_pkg::VEC_W,
  parameter int FILL_W   = sampler_pkg::FILL_W,
  parameter int FILL_CYC = (VEC_W + FILL_W - 1) / FILL_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [31:0]      seed,
  input  logic [15:0]      num_samples,
  input  logic [31:0]      max_tries,
  output logic [VEC_W-1:0] cand,
  input  logic             sat,
  output logic             sample_valid,
  input  logic             sample_ready,
  output logic [VEC_W-1:0] sample_data,
  output logic             busy,
  output logic             done,
  output logic             exhausted,
  output logic [31:0]      tries_cnt,
  output logic [15:0]      hits_cnt
);

  localparam int CTR_W = (FILL_CYC > 1) ? $clog2(FILL_CYC) : 1;

  drv_state_t       r_state;
  logic [CTR_W-1:0] r_fill_ctr;
  logic [VEC_W-1:0] r_cand;
  logic [15:0]      r_num;
  logic [31:0]      r_max;
  logic [31:0]      r_tries;
  logic [15:0]      r_hits;
  logic             r_valid;
  logic             r_busy;
  logic             r_done;
  logic             r_exh;

  logic [31:0]      w_lfsr_q;
  logic [31:0]      w_lfsr_next;
  logic             w_load;
  logic             w_step;
  logic [31:0]      w_tries_inc;
  logic [15:0]      w_hits_inc;

  assign w_load      = start && ((r_state == IDLE) || (r_state == DONE));
  assign w_step      = (r_state == FILL);
  assign w_lfsr_next = galois_step(w_lfsr_q);
  assign w_tries_inc = (r_tries == 32'hFFFF_FFFF) ? r_tries : r_tries + 32'd1;
  assign w_hits_inc  = r_hits + 16'd1;

  lfsr32_galois u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (w_load),
    .seed  (seed),
    .step  (w_step),
    .q     (w_lfsr_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_fill_ctr <= '0;
      r_cand     <= '0;
      r_num      <= '0;
      r_max      <= '0;
      r_tries    <= '0;
      r_hits     <= '0;
      r_valid    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_exh      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_num      <= num_samples;
            r_max      <= max_tries;
            r_tries    <= '0;
            r_hits     <= '0;
            r_exh      <= 1'b0;
            r_fill_ctr <= '0;
            if (num_samples == 16'd0) begin
              r_state <= DONE;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
            end else begin
              r_state <= FILL;
              r_busy  <= 1'b1;
            end
          end
        end
        FILL: begin
          r_cand <= {r_cand[VEC_W-FILL_W-1:0], w_lfsr_next};
          if (r_fill_ctr == CTR_W'(FILL_CYC - 1)) begin
            r_state <= CHECK;
          end else begin
            r_fill_ctr <= r_fill_ctr + 1'b1;
          end
        end
        CHECK: begin
          r_tries <= w_tries_inc;
          if (sat) begin
            r_state <= EMIT;
            r_valid <= 1'b1;
          end else if ((r_max != 32'd0) && (w_tries_inc == r_max)) begin
            r_state <= DONE;
            r_exh   <= 1'b1;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            r_state    <= FILL;
            r_fill_ctr <= '0;
          end
        end
        EMIT: begin
          // cand stays frozen here, so sample_data is stable until accepted.
          if (sample_ready) begin
            r_valid <= 1'b0;
            r_hits  <= w_hits_inc;
            if (w_hits_inc == r_num) begin
              r_state <= DONE;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
            end else if ((r_max != 32'd0) && (r_tries == r_max)) begin
              r_state <= DONE;
              r_exh   <= 1'b1;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
            end else begin
              r_state    <= FILL;
              r_fill_ctr <= '0;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign cand         = r_cand;
  assign sample_data  = r_cand;
  assign sample_valid = r_valid;
  assign busy         = r_busy;
  assign done         = r_done;
  assign exhausted    = r_exh;
  assign tries_cnt    = r_tries;
  assign hits_cnt     = r_hits;

endmodule

// File: tb/tb_constraint_sample_driver.sv
// Directed bench for constraint_sample_driver: stub and stand-in checkers,
// timing of samples and done, budget exhaustion, seeding, backpressure and reset.
module tb_constraint_sample_driver;

  localparam int VW = sampler_pkg::VEC_W;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [31:0]   seed = '0;
  logic [15:0]   num_samples = '0;
  logic [31:0]   max_tries = '0;
  logic [VW-1:0] cand;
  logic          sat;
  logic          sample_valid;
  logic          sample_ready = 1'b0;
  logic [VW-1:0] sample_data;
  logic          busy;
  logic          done;
  logic          exhausted;
  logic [31:0]   tries_cnt;
  logic [15:0]   hits_cnt;

  logic          stub_sat = 1'b0;
  logic          use_real = 1'b0;
  logic [15:0]   var_0;
  logic [31:0]   var_1;
  logic          real_x;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Stand-in generated checker: var_0 in the LSBs, var_1 packed directly above.
  assign var_0  = cand[15:0];
  assign var_1  = cand[47:16];
  assign real_x = (var_0[3:0] > 4'd7) ^ var_1[0];
  assign sat    = use_real ? real_x : stub_sat;

  constraint_sample_driver dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .seed         (seed),
    .num_samples  (num_samples),
    .max_tries    (max_tries),
    .cand         (cand),
    .sat          (sat),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .sample_data  (sample_data),
    .busy         (busy),
    .done         (done),
    .exhausted    (exhausted),
    .tries_cnt    (tries_cnt),
    .hits_cnt     (hits_cnt)
  );

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_step(input logic [31:0] s);
    logic [31:0] n;
    n = {1'b0, s[31:1]};
    if (s[0]) n = n ^ 32'h80200003;
    return n;
  endfunction

  // Reference evaluation of the stand-in checker on an unpacked sample.
  function automatic bit ref_x(input logic [VW-1:0] d);
    int unsigned v0, v1;
    v0 = d[15:0];
    v1 = d[47:16];
    return ((v0 % 16) >= 8) != ((v1 % 2) == 1);
  endfunction

  // n-th candidate (1-based) produced from a seed, plus the LFSR state after it.
  task automatic model(input logic [31:0] sd, input int n,
                       output logic [VW-1:0] c, output logic [31:0] st);
    logic [31:0] s;
    s = (sd == 0) ? 32'h1 : sd;
    c = '0;
    for (int i = 0; i < n * 13; i++) begin
      s = m_step(s);
      c = {c[VW-33:0], s};
    end
    st = s;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [31:0] sd, input logic [15:0] ns, input logic [31:0] mt);
    @(negedge clk);
    seed = sd;
    num_samples = ns;
    max_tries = mt;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  int v_edge[4];
  int nv;
  int done_edge;

  task automatic run(input int maxk);
    nv = 0;
    done_edge = -1;
    for (int i = 0; i < 4; i++) v_edge[i] = -1;
    for (int k = 1; k <= maxk; k++) begin
      tick();
      if (sample_valid) begin
        if (nv < 4) v_edge[nv] = k;
        nv++;
      end
      if (done) begin
        done_edge = k;
        break;
      end
    end
  endtask

  task automatic wait_valid(output int edge_k);
    edge_k = -1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (sample_valid) begin
        edge_k = k;
        break;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [VW-1:0] c0, exp_c, held;
    logic [31:0]   exp_s, s;
    logic [VW-1:0] exp_list[4];
    int            exp_tries, h, got, ek;
    bit            done_seen;

    // Reset state
    #12;
    chk("rst_cand", cand, '0);
    chk("rst_valid", sample_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_exh", exhausted, 1'b0);
    chk("rst_tries", tries_cnt, 0);
    chk("rst_hits", hits_cnt, 0);
    chk("rst_lfsr", dut.w_lfsr_q, 32'h1);
    @(negedge clk);
    rst_n = 1'b1;

    // Always-satisfied stub, three samples, ready tied high
    stub_sat = 1'b1;
    sample_ready = 1'b1;
    do_start(32'h12345678, 16'd3, 32'd0);
    chk("t1_busy", busy, 1'b1);
    run(80);
    chk("t1_nv", nv, 3);
    chk("t1_v0", v_edge[0], 14);
    chk("t1_v1", v_edge[1], 29);
    chk("t1_v2", v_edge[2], 44);
    chk("t1_done", done_edge, 45);
    chk("t1_tries", tries_cnt, 3);
    chk("t1_hits", hits_cnt, 3);
    chk("t1_exh", exhausted, 1'b0);
    chk("t1_busy_end", busy, 1'b0);
    model(32'h12345678, 3, exp_c, exp_s);
    chk("t1_last_cand", cand, exp_c);
    tick();
    chk("t1_done_1cyc", done, 1'b0);

    // Zero samples finishes immediately
    do_start(32'h5, 16'd0, 32'd0);
    chk("t0_done", done, 1'b1);
    chk("t0_busy", busy, 1'b0);

    // Never-satisfied stub with a budget of 5
    stub_sat = 1'b0;
    do_start(32'h77, 16'd3, 32'd5);
    run(100);
    chk("t2_nv", nv, 0);
    chk("t2_done", done_edge, 70);
    chk("t2_exh", exhausted, 1'b1);
    chk("t2_tries", tries_cnt, 5);
    chk("t2_hits", hits_cnt, 0);

    // Seed 0 must behave as seed 1
    do_start(32'h0, 16'd1, 32'd1);
    chk("t3_exh_clr", exhausted, 1'b0);
    chk("t3_tries_clr", tries_cnt, 0);
    tick();
    chk("t3_w0", cand[31:0], 32'h80200003);
    tick();
    chk("t3_w1_hi", cand[63:32], 32'h80200003);
    chk("t3_w1_lo", cand[31:0], 32'hC0300002);
    run(30);
    chk("t3_exh", exhausted, 1'b1);
    c0 = cand;
    do_start(32'h1, 16'd1, 32'd1);
    run(30);
    chk("t3_same", cand, c0);
    model(32'h1, 1, exp_c, exp_s);
    chk("t3_model", cand, exp_c);

    // Backpressure: ready low for 10 cycles
    stub_sat = 1'b1;
    sample_ready = 1'b0;
    do_start(32'hDEADBEEF, 16'd1, 32'd0);
    wait_valid(ek);
    chk("t4_vedge", ek, 14);
    model(32'hDEADBEEF, 1, exp_c, exp_s);
    chk("t4_data", sample_data, exp_c);
    held = sample_data;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t4_hold_valid", sample_valid, 1'b1);
      chk("t4_hold_data", sample_data, held);
      chk("t4_hold_hits", hits_cnt, 0);
      chk("t4_hold_lfsr", dut.w_lfsr_q, exp_s);
    end
    sample_ready = 1'b1;
    tick();
    chk("t4_hits", hits_cnt, 1);
    chk("t4_valid_drop", sample_valid, 1'b0);
    chk("t4_done", done, 1'b1);
    chk("t4_tries", tries_cnt, 1);

    // Stand-in checker: predict every emitted sample from the model
    s = 32'hACE1;
    exp_c = '0;
    h = 0;
    exp_tries = 0;
    for (int i = 1; i <= 200 && h < 4; i++) begin
      for (int j = 0; j < 13; j++) begin
        s = m_step(s);
        exp_c = {exp_c[VW-33:0], s};
      end
      if (ref_x(exp_c)) begin
        exp_list[h] = exp_c;
        h++;
        exp_tries = i;
      end
    end
    use_real = 1'b1;
    sample_ready = 1'b1;
    do_start(32'hACE1, 16'd4, 32'd0);
    got = 0;
    done_seen = 1'b0;
    for (int k = 1; k <= 5000; k++) begin
      tick();
      if (sample_valid) begin
        chk("t5_ref_x", ref_x(sample_data), 1'b1);
        if (got < 4) chk("t5_data", sample_data, exp_list[got]);
        got++;
      end
      if (done) begin
        done_seen = 1'b1;
        break;
      end
    end
    chk("t5_done_seen", done_seen, 1'b1);
    chk("t5_got", got, 4);
    chk("t5_hits", hits_cnt, 4);
    chk("t5_tries", tries_cnt, exp_tries);
    use_real = 1'b0;

    // Reset during EMIT, then restart with the same seed
    stub_sat = 1'b1;
    sample_ready = 1'b0;
    do_start(32'h0BADF00D, 16'd2, 32'd0);
    wait_valid(ek);
    chk("t6_vedge", ek, 14);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", sample_valid, 1'b0);
    chk("t6_rst_cand", cand, '0);
    chk("t6_rst_busy", busy, 1'b0);
    chk("t6_rst_tries", tries_cnt, 0);
    chk("t6_rst_hits", hits_cnt, 0);
    chk("t6_rst_done", done, 1'b0);
    chk("t6_rst_exh", exhausted, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    do_start(32'h0BADF00D, 16'd1, 32'd0);
    wait_valid(ek);
    chk("t6_re_vedge", ek, 14);
    model(32'h0BADF00D, 1, exp_c, exp_s);
    chk("t6_re_data", sample_data, exp_c);
    sample_ready = 1'b1;
    tick();
    chk("t6_re_done", done, 1'b1);
    chk("t6_re_hits", hits_cnt, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
